// File: rtl/dmem_store_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_store_responder_if
//   M-stage data-memory port between the core (master) and the data memory /
//   store responder (slave).
//   MemWriteM   core -> mem  store strobe, one store per cycle while high
//   DataAdrM    core -> mem  byte address for loads and stores
//   WriteDataM  core -> mem  store data
//   ReadDataM   mem -> core  combinational load data
// ----------------------------------------------------------------------------
interface dmem_store_responder_if;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master (
        output MemWriteM,
        output DataAdrM,
        output WriteDataM,
        input  ReadDataM
    );

    modport slave (
        input  MemWriteM,
        input  DataAdrM,
        input  WriteDataM,
        output ReadDataM
    );
endinterface

// File: rtl/dmem_store_responder.sv
// ----------------------------------------------------------------------------
// dmem_store_responder
//   Word-addressed data RAM for the five-stage core plus a mailbox FSM that
//   watches stores and decides the self-test verdict (PASS / FAIL / TIMEOUT).
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears status, not the RAM
//   bus         M-stage data port (slave side): MemWriteM, DataAdrM,
//               WriteDataM in; ReadDataM out (combinational)
//   Done        status has left RUN
//   Pass        status is PASS
//   FailCode    0 none, 1 bad mailbox data, 2 bad address, 3 timeout
//   StoreCount  stores seen while in RUN, saturating at 16'hFFFF
//   CycleCount  cycles spent in RUN, frozen once RUN is left
// ----------------------------------------------------------------------------
module dmem_store_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] PASS_ADDR = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd25,
  parameter int unsigned TIMEOUT   = 4096,
  parameter              INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_store_responder_if.slave bus,
  output logic                  Done,
  output logic                  Pass,
  output logic [1:0]            FailCode,
  output logic [15:0]           StoreCount,
  output logic [31:0]           CycleCount
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH);
  // Last RUN cycle before the watchdog fires; unused when TIMEOUT is 0.
  localparam logic [31:0] TO_LAST    = (TIMEOUT == 0) ? '0 : 32'(TIMEOUT - 1);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_BAD_DATA = 2'd1;
  localparam logic [1:0] FC_BAD_ADDR = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_fail_code;
  logic [1:0]    w_fail_code_next;
  logic [15:0]   r_store_count;
  logic [31:0]   r_cycle_count;

  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic          w_timeout_hit;

  assign w_index    = bus.DataAdrM[AW+1:2];
  assign w_in_range = (bus.DataAdrM < BYTE_LIMIT) && (bus.DataAdrM[1:0] == 2'b00);

  // Read-before-write: a load to the word being stored returns the old word.
  assign bus.ReadDataM = w_in_range ? r_mem[w_index] : '0;

  always_ff @(posedge clk) begin
    if (bus.MemWriteM && w_in_range) begin
      r_mem[w_index] <= bus.WriteDataM;
    end
  end

  assign w_timeout_hit = (TIMEOUT != 0) && (r_cycle_count == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_fail_code <= FC_NONE;
    end else begin
      r_state     <= w_state_next;
      r_fail_code <= w_fail_code_next;
    end
  end

  // A deciding store in the last RUN cycle takes priority over the watchdog.
  always_comb begin
    w_state_next     = r_state;
    w_fail_code_next = r_fail_code;
    if (r_state == ST_RUN) begin
      if (bus.MemWriteM) begin
        if (!w_in_range) begin
          w_state_next     = ST_FAIL;
          w_fail_code_next = FC_BAD_ADDR;
        end else if (bus.DataAdrM == PASS_ADDR) begin
          if (bus.WriteDataM == PASS_DATA) begin
            w_state_next = ST_PASS;
          end else begin
            w_state_next     = ST_FAIL;
            w_fail_code_next = FC_BAD_DATA;
          end
        end
      end
      if ((w_state_next == ST_RUN) && w_timeout_hit) begin
        w_state_next     = ST_FAIL;
        w_fail_code_next = FC_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store_count <= '0;
      r_cycle_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (bus.MemWriteM && (r_store_count != 16'hFFFF)) begin
        r_store_count <= r_store_count + 16'd1;
      end
    end
  end

  assign Done       = (r_state != ST_RUN);
  assign Pass       = (r_state == ST_PASS);
  assign FailCode   = r_fail_code;
  assign StoreCount = r_store_count;
  assign CycleCount = r_cycle_count;

endmodule
